conbus_slave_dec: RTL and testbench

Slave-side responder/decoder for the conbus Wishbone interconnect: takes the single cycle stream from the granted master, decodes the address to one of seven slaves, drives that slave's cycle/strobe and returns its data and acknowledge. It terminates accesses to unmapped space with an error. A watchdog also terminates accesses to a slave that never acknowledges. Sits between the master arbiter/mux and the slave ports.

---
 rtl/conbus_pkg.sv | 22 ++
 rtl/conbus_wdog.sv | 33 +++
 rtl/conbus_slave_dec.sv | 134 +++++++++++++
 tb/tb_conbus_slave_dec.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conbus_pkg.sv
// conbus_pkg: shared definitions for the conbus slave-side decoder.
//   - FSM state encoding (S_IDLE, S_BUSY, S_ERR)
//   - slave count, unmapped slave index, width of the address decode field
package conbus_pkg;

  localparam int N_SLAVES = 7;
  localparam int DEC_W    = 3;

  // Index 7 of the top address field has no slave behind it.
  localparam logic [DEC_W-1:0] UNMAPPED_IDX = 3'd7;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_BUSY_ENC = 2'd1;
  localparam logic [1:0] ST_ERR_ENC  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_BUSY = ST_BUSY_ENC,
    S_ERR  = ST_ERR_ENC
  } state_t;

endpackage

// File: rtl/conbus_wdog.sv
// conbus_wdog: watchdog cycle counter for a slave access.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : increment by one per cycle
//   expired    : counter currently equals TIMEOUT-1
module conbus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/conbus_slave_dec.sv
// conbus_slave_dec: slave-side responder/decoder for the conbus interconnect.
// Decodes the granted master's address (top 3 bits) to one of seven slaves,
// drives that slave's cyc/stb, and returns its read data and acknowledge.
// Unmapped accesses and accesses to a silent slave end with a one-cycle error.
//
// Handshake: a master request is m_cyc_i & m_stb_i sampled in IDLE. It is
// terminated by exactly one cycle of m_ack_o (selected slave acked) or
// m_err_o (unmapped or watchdog expiry). Dropping m_cyc_i while BUSY aborts
// the access with no termination; any later slave ack is ignored.
//
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i   : master address, write data, byte selects
//   m_we_i/m_cyc_i/m_stb_i    : master control
//   m_dat_o, m_ack_o, m_err_o : read data and termination to the master
//   s_adr_o/s_dat_o/s_sel_o/s_we_o : shared pass-through to all slaves
//   s_cyc_o, s_stb_o          : one-hot per-slave cycle/strobe
//   s_dat_i, s_ack_i          : flattened slave read data, per-slave ack
//   dbg_state                 : current FSM state encoding
module conbus_slave_dec
  import conbus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [ADDR_W-1:0]          m_adr_i,
  input  logic [DATA_W-1:0]          m_dat_i,
  input  logic [DATA_W/8-1:0]        m_sel_i,
  input  logic                       m_we_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  output logic [DATA_W-1:0]          m_dat_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic [ADDR_W-1:0]          s_adr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic                       s_we_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  output logic [1:0]                 dbg_state
);

  state_t           state;
  logic [DEC_W-1:0] idx;
  logic [DEC_W-1:0] dec_idx;
  logic             busy;
  logic             sel_ack;
  logic [DATA_W-1:0] sel_dat;
  logic             expired;

  assign dec_idx   = m_adr_i[ADDR_W-1 -: DEC_W];
  assign busy      = (state == S_BUSY);
  assign dbg_state = state;

  // Shared pass-through: slaves qualify these with their own cyc/stb.
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

  // Select the addressed slave's ack and data; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (idx == DEC_W'(k)) begin
        sel_ack = s_ack_i[k];
        sel_dat = s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (busy && idx == DEC_W'(k)) begin
        s_cyc_o[k] = 1'b1;
        s_stb_o[k] = 1'b1;
      end
    end
  end

  // An aborting master (cyc low) never sees an ack, even if the slave
  // happens to respond in the same cycle.
  assign m_ack_o = busy & m_cyc_i & sel_ack;
  assign m_dat_o = busy ? sel_dat : '0;
  assign m_err_o = (state == S_ERR);

  // Counter runs only while BUSY and is held at 0 otherwise, so every
  // access starts its timeout window from 0.
  conbus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (!busy),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            idx   <= dec_idx;
            state <= (dec_idx == UNMAPPED_IDX) ? S_ERR : S_BUSY;
          end
        end
        S_BUSY: begin
          // Abort and ack both return to IDLE; ack beats a same-cycle expiry.
          if (!m_cyc_i || sel_ack) begin
            state <= S_IDLE;
          end else if (expired) begin
            state <= S_ERR;
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conbus_slave_dec.sv
module tb_conbus_slave_dec;
  import conbus_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  logic [ADDR_W-1:0]          m_adr_i;
  logic [DATA_W-1:0]          m_dat_i;
  logic [DATA_W/8-1:0]        m_sel_i;
  logic                       m_we_i, m_cyc_i, m_stb_i;
  logic [DATA_W-1:0]          m_dat_o;
  logic                       m_ack_o, m_err_o;
  logic [ADDR_W-1:0]          s_adr_o;
  logic [DATA_W-1:0]          s_dat_o;
  logic [DATA_W/8-1:0]        s_sel_o;
  logic                       s_we_o;
  logic [N_SLAVES-1:0]        s_cyc_o, s_stb_o;
  logic [N_SLAVES*DATA_W-1:0] s_dat_i;
  logic [N_SLAVES-1:0]        s_ack_i;
  logic [1:0]                 dbg_state;

  conbus_slave_dec #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cyc();
    @(negedge sys_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ack"}, 64'(m_ack_o), 64'd0);
    chk({tag, "_err"}, 64'(m_err_o), 64'd0);
    chk({tag, "_dat"}, 64'(m_dat_o), 64'd0);
    chk({tag, "_cyc"}, 64'(s_cyc_o), 64'd0);
    chk({tag, "_stb"}, 64'(s_stb_o), 64'd0);
  endtask

  task automatic request(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
    m_adr_i = adr;
    m_dat_i = dat;
    m_sel_i = sel;
    m_we_i  = we;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    s_ack_i = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    sys_rst_n = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    s_ack_i = '0;
    for (int k = 0; k < N_SLAVES; k++) s_dat_i[k*DATA_W +: DATA_W] = 32'h1111_1111 * (k + 1);
    s_dat_i[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;

    // Reset state
    #2;
    idle_outputs("rst");
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE_ENC));
    next_cyc(); next_cyc();
    sys_rst_n = 1'b1;

    // Read from slave 1, ack on the third strobe cycle
    next_cyc();
    request(32'h2000_0010, 32'h0, 4'hF, 1'b0);
    settle();
    chk("rd_decode_stb", 64'(s_stb_o), 64'd0);
    chk("rd_decode_dat", 64'(m_dat_o), 64'd0);
    chk("rd_adr_pass", 64'(s_adr_o), 64'h2000_0010);
    next_cyc(); settle();
    chk("rd_stb1", 64'(s_stb_o), 64'b0000010);
    chk("rd_cyc1", 64'(s_cyc_o), 64'b0000010);
    chk("rd_noack1", 64'(m_ack_o), 64'd0);
    chk("rd_state", 64'(dbg_state), 64'(ST_BUSY_ENC));
    next_cyc(); settle();
    chk("rd_stb2", 64'(s_stb_o), 64'b0000010);
    next_cyc();
    s_ack_i = 7'b0000010;
    settle();
    chk("rd_ack", 64'(m_ack_o), 64'd1);
    chk("rd_data", 64'(m_dat_o), 64'hDEAD_BEEF);
    chk("rd_err", 64'(m_err_o), 64'd0);
    next_cyc();
    release_bus();
    settle();
    idle_outputs("rd_done");
    chk("rd_idle", 64'(dbg_state), 64'(ST_IDLE_ENC));

    // Write to slave 6
    next_cyc();
    request(32'hC000_0000, 32'h1234_5678, 4'b0011, 1'b1);
    settle();
    chk("wr_dat_pass", 64'(s_dat_o), 64'h1234_5678);
    chk("wr_sel_pass", 64'(s_sel_o), 64'b0011);
    chk("wr_we_pass", 64'(s_we_o), 64'd1);
    next_cyc(); settle();
    chk("wr_cyc6", 64'(s_cyc_o), 64'b1000000);
    next_cyc(); settle();
    chk("wr_cyc6_hold", 64'(s_cyc_o), 64'b1000000);
    s_ack_i = 7'b1000000;
    settle();
    chk("wr_ack", 64'(m_ack_o), 64'd1);
    next_cyc();
    release_bus();
    settle();
    idle_outputs("wr_done");

    // Unmapped access
    next_cyc();
    request(32'hE000_0000, 32'h0, 4'hF, 1'b0);
    settle();
    chk("um_err_n", 64'(m_err_o), 64'd0);
    next_cyc(); settle();
    chk("um_err_n1", 64'(m_err_o), 64'd1);
    chk("um_cyc", 64'(s_cyc_o), 64'd0);
    chk("um_ack", 64'(m_ack_o), 64'd0);
    release_bus();
    next_cyc(); settle();
    idle_outputs("um_done");

    // Timeout: slave 3 never acks
    next_cyc();
    request(32'h6000_0000, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < TIMEOUT; c++) begin
      next_cyc(); settle();
      chk($sformatf("to_stb%0d", c), 64'(s_stb_o), 64'b0001000);
      chk($sformatf("to_err%0d", c), 64'(m_err_o), 64'd0);
    end
    next_cyc(); settle();
    chk("to_err", 64'(m_err_o), 64'd1);
    chk("to_stb_drop", 64'(s_stb_o), 64'd0);
    release_bus();
    next_cyc(); settle();
    idle_outputs("to_done");

    // Ack on the last timeout cycle wins
    next_cyc();
    request(32'h6000_0000, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < TIMEOUT - 1; c++) next_cyc();
    next_cyc();
    s_ack_i = 7'b0001000;
    settle();
    chk("race_stb", 64'(s_stb_o), 64'b0001000);
    chk("race_ack", 64'(m_ack_o), 64'd1);
    chk("race_data", 64'(m_dat_o), 64'h4444_4444);
    next_cyc();
    release_bus();
    settle();
    idle_outputs("race_done");

    // Wrong-slave ack ignored, then master abort
    next_cyc();
    request(32'h4000_0000, 32'h0, 4'hF, 1'b0);
    next_cyc();
    s_ack_i = 7'b0100000;
    settle();
    chk("ws_stb", 64'(s_stb_o), 64'b0000100);
    chk("ws_noack", 64'(m_ack_o), 64'd0);
    next_cyc(); settle();
    chk("ws_still_busy", 64'(s_stb_o), 64'b0000100);
    release_bus();
    settle();
    chk("ab_noack", 64'(m_ack_o), 64'd0);
    next_cyc();
    s_ack_i = 7'b0000100;
    settle();
    idle_outputs("ab_late");
    next_cyc(); settle();
    chk("ab_noerr", 64'(m_err_o), 64'd0);
    s_ack_i = '0;

    // Reset pulse mid-BUSY
    next_cyc();
    request(32'h8000_0000, 32'h0, 4'hF, 1'b0);
    next_cyc(); settle();
    chk("rs_stb", 64'(s_stb_o), 64'b0010000);
    #2;
    sys_rst_n = 1'b0;
    settle();
    idle_outputs("rs_async");
    chk("rs_adr_pass", 64'(s_adr_o), 64'h8000_0000);
    next_cyc();
    sys_rst_n = 1'b1;
    settle();
    chk("rs_rel_stb", 64'(s_stb_o), 64'd0);
    next_cyc(); settle();
    chk("rs_redecode", 64'(s_stb_o), 64'b0010000);
    s_ack_i = 7'b0010000;
    settle();
    chk("rs_ack", 64'(m_ack_o), 64'd1);
    chk("rs_data", 64'(m_dat_o), 64'h5555_5555);
    next_cyc();
    release_bus();
    settle();
    idle_outputs("rs_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
